sid_voice_sched: RTL and testbench

SID_VOICE_SCHED -- requirements
Module: sid_voice_sched

---
 rtl/sid_voice_sched.sv | 62 ++++++
 tb/tb_sid_voice_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sid_voice_sched.sv
// sid_voice_sched: sequences the four SID clock phases across VOICES voices on one shared datapath and arbitrates register-file writes.
module sid_voice_sched #(
  parameter int VOICES = 3
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tick,
  input  logic       bus_req,
  output logic       bus_gnt,
  output logic [3:0] phase,
  output logic [1:0] voice,
  output logic [1:0] src_voice,
  output logic       st_we,
  output logic       busy,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, RUN, GNT} state_t;
  localparam logic [1:0] VL = 2'(VOICES - 1);
  state_t     state, n_state;
  logic [1:0] stage, n_stage, n_voice;
  logic       last;
  assign last = state == RUN && stage == 2'd3 && voice == VL;
  always_comb begin
    n_state = state;
    n_stage = 2'd0;
    n_voice = 2'd0;
    case (state)
      IDLE: n_state = tick ? RUN : bus_req ? GNT : IDLE;
      RUN: begin
        n_state = last ? (bus_req ? GNT : IDLE) : RUN;
        n_stage = last ? 2'd0 : voice == VL ? stage + 2'd1 : stage;
        n_voice = last || voice == VL ? 2'd0 : voice + 2'd1;
      end
      GNT: n_state = tick ? RUN : IDLE;
      default: n_state = IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      stage     <= 2'd0;
      voice     <= 2'd0;
      src_voice <= 2'd0;
      phase     <= 4'd0;
      st_we     <= 1'b0;
      busy      <= 1'b0;
      bus_gnt   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= n_state;
      stage     <= n_stage;
      voice     <= n_voice;
      src_voice <= n_state == RUN ? (n_voice == 2'd0 ? VL : n_voice - 2'd1) : 2'd0;
      phase     <= n_state == RUN ? 4'd1 << n_stage : 4'd0;
      st_we     <= n_state == RUN;
      busy      <= n_state == RUN;
      bus_gnt   <= n_state == GNT;
      overrun   <= overrun | (tick && state == RUN);
    end
  end
endmodule

// File: tb/tb_sid_voice_sched.sv
// tb_sid_voice_sched: directed checks of phase sequencing, grant arbitration, overrun and reset.
module tb_sid_voice_sched;
  logic clk = 1'b0, res = 1'b1, tick = 1'b0, bus_req = 1'b0;
  logic bus_gnt, st_we, busy, overrun, bus_gnt2, st_we2, busy2, overrun2;
  logic [3:0] phase, phase2;
  logic [1:0] voice, src_voice, voice2, src_voice2;
  int checks = 0, failures = 0;

  sid_voice_sched #(.VOICES(3)) dut (
    .clk(clk), .res(res), .tick(tick), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .phase(phase), .voice(voice), .src_voice(src_voice), .st_we(st_we),
    .busy(busy), .overrun(overrun));

  sid_voice_sched #(.VOICES(2)) dut2 (
    .clk(clk), .res(res), .tick(tick), .bus_req(bus_req), .bus_gnt(bus_gnt2),
    .phase(phase2), .voice(voice2), .src_voice(src_voice2), .st_we(st_we2),
    .busy(busy2), .overrun(overrun2));

  always #5 clk = ~clk;

  wire [11:0] obs  = {bus_gnt, busy, st_we, overrun, voice, src_voice, phase};
  wire [11:0] obs2 = {bus_gnt2, busy2, st_we2, overrun2, voice2, src_voice2, phase2};

  function automatic logic [11:0] ex(logic g, logic b, logic o, logic [1:0] v, logic [1:0] s, logic [3:0] p);
    return {g, b, b, o, v, s, p};
  endfunction

  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(string tag, int i, logic o);
    chk(tag, obs, ex(1'b0, 1'b1, o, 2'(i % 3), 2'((i + 2) % 3), 4'(1 << (i / 3))));
  endtask

  task automatic idle(string tag, logic o);
    chk(tag, obs, ex(1'b0, 1'b0, o, 2'd0, 2'd0, 4'd0));
  endtask

  task automatic start();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    idle("reset", 1'b0);
    chk("reset_v2", obs2, 12'd0);
    res = 1'b0;
    cyc();
    idle("idle_after_reset", 1'b0);
    // single sequence, both voice counts
    start();
    for (int i = 0; i < 12; i++) begin
      strobe("seq1", i, 1'b0);
      chk("seq1_v2", obs2, i < 8 ? ex(1'b0, 1'b1, 1'b0, 2'(i % 2), 2'((i + 1) % 2), 4'(1 << (i / 2)))
                                 : 12'd0);
      cyc();
    end
    idle("seq1_end", 1'b0);
    cyc();
    idle("seq1_stay", 1'b0);
    // request raised during sequence
    start();
    for (int i = 0; i < 12; i++) begin
      if (i == 2) bus_req = 1'b1;
      strobe("req_mid", i, 1'b0);
      cyc();
    end
    chk("req_gnt", obs, ex(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0));
    bus_req = 1'b0;
    cyc();
    idle("req_gnt_once", 1'b0);
    // tick has priority over simultaneous request
    tick = 1'b1; bus_req = 1'b1;
    cyc();
    tick = 1'b0;
    for (int i = 0; i < 12; i++) begin
      strobe("prio", i, 1'b0);
      cyc();
    end
    chk("prio_gnt", obs, ex(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0));
    bus_req = 1'b0;
    cyc();
    idle("prio_after", 1'b0);
    // tick during grant starts a sequence right after it
    bus_req = 1'b1;
    cyc();
    chk("gnt_tick_gnt", obs, ex(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0));
    bus_req = 1'b0;
    start();
    for (int i = 0; i < 12; i++) begin
      strobe("gnt_tick_seq", i, 1'b0);
      cyc();
    end
    idle("gnt_tick_end", 1'b0);
    // overrun at RUN clk 6 and at final clk
    start();
    for (int i = 0; i < 12; i++) begin
      strobe("ovr", i, i > 5);
      tick = (i == 5 || i == 11);
      cyc();
      tick = 1'b0;
    end
    idle("ovr_end", 1'b1);
    cyc();
    idle("ovr_no_restart", 1'b1);
    // reset mid-sequence
    start();
    for (int i = 0; i < 4; i++) cyc();
    strobe("pre_res", 4, 1'b1);
    res = 1'b1;
    cyc();
    res = 1'b0;
    idle("res_abort", 1'b0);
    cyc();
    idle("res_quiet", 1'b0);
    // inputs coinciding with reset are ignored
    res = 1'b1; tick = 1'b1; bus_req = 1'b1;
    cyc();
    res = 1'b0; tick = 1'b0; bus_req = 1'b0;
    cyc();
    idle("res_ignore", 1'b0);
    start();
    for (int i = 0; i < 12; i++) begin
      strobe("post_res", i, 1'b0);
      cyc();
    end
    idle("post_res_end", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
